multi_channel_counter: RTL
==========================

Name: multi_channel_counter

Overview:
- Parametrised successor to the single up/down counter.
- Holds CHANNELS independent up/down counters, e.g. one per R/G/B intensity channel.
- Adds a shared runtime upper limit, wrap or saturate mode, per-channel parallel load, boundary flags and a one-cycle boundary-event pulse.
- Sits between button/prescaler logic and the PWM generators of the RGB datapath.

Parameters:
COUNTER_WIDTH, 8, bit width of each channel counter.
CHANNELS, 3, number of independent counter channels (>=1).

Ports:
clock  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
clock_enable  input  1  global count enable (typically a prescaler tick); gates counting only.
count_up  input  CHANNELS  per-channel increment request.
count_down  input  CHANNELS  per-channel decrement request.
load  input  CHANNELS  per-channel parallel load strobe.
load_value  input  CHANNELS*COUNTER_WIDTH  packed load data; channel i at [i*COUNTER_WIDTH +: COUNTER_WIDTH].
mode  input  1  counter_mode_t: 0 = MODE_WRAP, 1 = MODE_SATURATE; shared by all channels.
limit  input  COUNTER_WIDTH  inclusive upper bound; legal range per channel is 0..limit.
value  output  CHANNELS*COUNTER_WIDTH  packed registered counter values, same packing as load_value.
at_max  output  CHANNELS  value_i >= limit.
at_min  output  CHANNELS  value_i == 0.
boundary_pulse  output  CHANNELS  one-cycle registered pulse on a boundary event.

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset: all values 0 and boundary_pulse 0. Flags are then at_min = all ones and at_max_i = (limit == 0).
- Per-channel priority each rising edge: reset > load > out-of-range clamp > count.
- Load:
  - When load_i=1, value_i <= min(load_value_i, limit). clock_enable is ignored. No pulse.
- Clamp:
  - When not loading, clock_enable=1 and value_i > limit (limit was lowered), value_i <= limit. No pulse.
  - Count requests are ignored that cycle.
- Count (clock_enable=1, value_i <= limit):
  - up only, value_i < limit: value_i + 1.
  - up only, value_i == limit:
    - MODE_WRAP: value_i <= 0 and pulse.
    - MODE_SATURATE: hold and pulse (blocked request is still reported).
  - down only, value_i > 0: value_i - 1.
  - down only, value_i == 0:
    - MODE_WRAP: value_i <= limit and pulse.
    - MODE_SATURATE: hold and pulse.
  - up and down together: hold, no pulse. This differs from the older block, which gave up priority.
  - Neither request: hold.
- clock_enable=0: counts are frozen; only load and reset act.
- Latency and timing:
  - value updates one cycle after the qualifying edge.
  - boundary_pulse_i is registered and valid in the same cycle as the resulting value. It is high for exactly one cycle per event and is otherwise 0, including during load and reset.
- at_max and at_min are combinational from the registered value and the current limit, with no extra latency.
- limit == 0:
  - Every up or down request is a boundary event.
  - Wrap mode yields value 0 either way.
- Arithmetic is COUNTER_WIDTH unsigned. Implementation must not rely on natural modulo-2^W overflow, because limit may be below 2^W-1.
- Channels are fully independent except for the shared clock_enable, mode and limit.

Decomposition:
- Package multi_channel_counter_pkg holds:
  - typedef enum logic {MODE_WRAP, MODE_SATURATE} counter_mode_t;
  - localparam defaults for COUNTER_WIDTH and CHANNELS.
- Sub-module counter_channel implements one channel: value register, pulse register and flag logic.
- Top level is a generate loop over CHANNELS plus vector packing/unpacking.

Test Plan:
All scenarios use W=4, CHANNELS=3, limit=9.
1. Reset:
   - Stimulus: reset high 2 cycles, then release.
   - Response: value=0 on all channels, at_min=3'b111, at_max=3'b000, boundary_pulse=0.
2. Wrap up:
   - Stimulus: MODE_WRAP, ch0 load 8, then 2 enabled up cycles.
   - Response: ch0 value 9 (at_max=1), then 0 with boundary_pulse[0]=1 for one cycle.
3. Saturate down:
   - Stimulus: MODE_SATURATE, ch1 at 0, 3 enabled down cycles.
   - Response: value stays 0, boundary_pulse[1]=1 each cycle, ch0 and ch2 unaffected.
4. Load clamp and lowered limit:
   - Load clamp: load 15 on ch2 -> value 9.
   - Lowered limit: then set limit=5 with clock_enable=1 and no requests -> value 5 next cycle, no pulse.
5. Simultaneous and gated requests:
   - up and down both high on ch0 at value 4 -> holds 4.
   - clock_enable=0 with up on all channels -> no change.
   - load while clock_enable=0 -> load takes effect.
6. Reset mid-operation:
   - Stimulus: reset asserted in the same cycle as a wrap event on ch0.
   - Response: value=0, boundary_pulse=0 next cycle.

Source files
------------

// File: rtl/multi_channel_counter_pkg.sv
// Shared types and default sizing for the multi-channel up/down counter.
// Also holds the counting mode that all channels share.
package multi_channel_counter_pkg;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } counter_mode_t;

    localparam int DEFAULT_COUNTER_WIDTH = 8;
    localparam int DEFAULT_CHANNELS      = 3;

endpackage

// File: rtl/counter_channel.sv
// One bounded up/down counter channel.
// Holds the value register, the boundary-event pulse register and the at_max/at_min flags.
module counter_channel
    import multi_channel_counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clock_enable,
    input  logic                     count_up,
    input  logic                     count_down,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    input  counter_mode_t            mode,
    input  logic [COUNTER_WIDTH-1:0] limit,
    output logic [COUNTER_WIDTH-1:0] value,
    output logic                     at_max,
    output logic                     at_min,
    output logic                     boundary_pulse
);

    localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] ZERO = '0;

    logic [COUNTER_WIDTH-1:0] value_p1;
    logic                     pulse_p1;
    logic [COUNTER_WIDTH-1:0] next_value;
    logic                     next_pulse;

    function automatic logic [COUNTER_WIDTH-1:0] clamp_to_limit(
        input logic [COUNTER_WIDTH-1:0] v,
        input logic [COUNTER_WIDTH-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

    // Increment/decrement stay strictly inside 0..limit, so plain W-bit math
    // never overflows; the wrap targets are chosen explicitly rather than
    // relying on modulo-2^W behaviour.
    always_comb begin
        next_value = value_p1;
        next_pulse = 1'b0;
        if (load) begin
            next_value = clamp_to_limit(load_value, limit);
        end else if (clock_enable) begin
            if (value_p1 > limit) begin
                next_value = limit;
            end else if (count_up && !count_down) begin
                if (value_p1 < limit) begin
                    next_value = value_p1 + ONE;
                end else begin
                    next_pulse = 1'b1;
                    if (mode == MODE_WRAP) next_value = ZERO;
                end
            end else if (count_down && !count_up) begin
                if (value_p1 > ZERO) begin
                    next_value = value_p1 - ONE;
                end else begin
                    next_pulse = 1'b1;
                    if (mode == MODE_WRAP) next_value = limit;
                end
            end
        end
    end

    // ---- stage p1: registered value and boundary pulse ----
    always_ff @(posedge clock) begin
        if (reset) begin
            value_p1 <= ZERO;
            pulse_p1 <= 1'b0;
        end else begin
            value_p1 <= next_value;
            pulse_p1 <= next_pulse;
        end
    end

    assign value          = value_p1;
    assign boundary_pulse = pulse_p1;
    assign at_max         = (value_p1 >= limit);
    assign at_min         = (value_p1 == ZERO);

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of CHANNELS independent bounded up/down counters sharing enable, mode and limit.
// Feeds the per-channel PWM generators of the RGB datapath.
module multi_channel_counter
    import multi_channel_counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int CHANNELS      = DEFAULT_CHANNELS
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clock_enable,
    input  logic [CHANNELS-1:0]               count_up,
    input  logic [CHANNELS-1:0]               count_down,
    input  logic [CHANNELS-1:0]               load,
    input  logic [CHANNELS*COUNTER_WIDTH-1:0] load_value,
    input  counter_mode_t                     mode,
    input  logic [COUNTER_WIDTH-1:0]          limit,
    output logic [CHANNELS*COUNTER_WIDTH-1:0] value,
    output logic [CHANNELS-1:0]               at_max,
    output logic [CHANNELS-1:0]               at_min,
    output logic [CHANNELS-1:0]               boundary_pulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        counter_channel #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_channel (
            .clock         (clock),
            .reset         (reset),
            .clock_enable  (clock_enable),
            .count_up      (count_up[i]),
            .count_down    (count_down[i]),
            .load          (load[i]),
            .load_value    (load_value[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .mode          (mode),
            .limit         (limit),
            .value         (value[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .at_max        (at_max[i]),
            .at_min        (at_min[i]),
            .boundary_pulse(boundary_pulse[i])
        );
    end

endmodule
